// File: rtl/hamming_frame_pkg.sv
// hamming_frame_pkg: framing constants shared by the inserter and the receive-side synchroniser
package hamming_frame_pkg;
  localparam int CW_W = 7;
  localparam int SYNC_W = 8;
  localparam logic [SYNC_W-1:0] SYNC_WORD = 8'b11100100;
  typedef enum logic [1:0] {FILL, SEND_SYNC, SEND_PAYLOAD} frame_tx_state_t;
endpackage

// File: rtl/frame_payload_buffer.sv
// frame_payload_buffer: serial-in/serial-out payload store, oldest bit presented at head
module frame_payload_buffer
#(
  parameter int W = 56
) (
  input  logic clk,
  input  logic rst,
  input  logic shift_in,
  input  logic shift_out,
  input  logic serial,
  output logic head
);
  import hamming_frame_pkg::*;
  logic [W-1:0] sr;
  assign head = sr[W-1];
  // shift toward the head on either accept or emit; emit backfills zeros
  always_ff @(posedge clk or posedge rst)
    if (rst) sr <= '0;
    else if (shift_in || shift_out) sr <= {sr[W-2:0], shift_in & serial};
endmodule

// File: rtl/hamming_frame_inserter.sv
// hamming_frame_inserter: buffers a payload of codeword bits then emits sync word + payload
module hamming_frame_inserter
#(
  parameter int CW_W = hamming_frame_pkg::CW_W,
  parameter int CW_PER_FRAME = 8,
  parameter int SYNC_W = hamming_frame_pkg::SYNC_W,
  parameter logic [SYNC_W-1:0] SYNC_WORD = hamming_frame_pkg::SYNC_WORD
) (
  input  logic       clk_out,
  input  logic       rst,
  input  logic       data_in,
  input  logic       data_valid,
  output logic       data_in_ready,
  output logic       data_out,
  output logic       data_out_valid,
  output logic       frame_start,
  output logic [7:0] frame_cnt
);
  import hamming_frame_pkg::*;
  localparam int PAYLOAD_W = CW_W * CW_PER_FRAME;
  localparam int CNT_W = $clog2(SYNC_W > PAYLOAD_W ? SYNC_W : PAYLOAD_W);
  localparam logic [CNT_W-1:0] PAY_LAST = CNT_W'(PAYLOAD_W - 1);
  localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(SYNC_W - 1);
  localparam logic [CNT_W-1:0] SYNC_PENULT = CNT_W'(SYNC_W - 2);
  frame_tx_state_t state;
  logic [CNT_W-1:0] bit_cnt;
  logic head, accept, shift_out, sync_bit;
  assign data_in_ready = state == FILL;
  assign accept = data_valid && data_in_ready;
  assign shift_out = (state == SEND_SYNC && bit_cnt == SYNC_LAST) || (state == SEND_PAYLOAD && bit_cnt != PAY_LAST);
  assign sync_bit = 1'(SYNC_WORD >> (SYNC_PENULT - bit_cnt));
  frame_payload_buffer #(.W(PAYLOAD_W)) u_buf (
    .clk(clk_out),
    .rst(rst),
    .shift_in(accept),
    .shift_out(shift_out),
    .serial(data_in),
    .head(head)
  );
  // frame FSM: bit_cnt is reused per phase and cleared at every phase change
  always_ff @(posedge clk_out or posedge rst)
    if (rst) begin
      state <= FILL;
      bit_cnt <= '0;
      data_out <= 1'b0;
      data_out_valid <= 1'b0;
      frame_start <= 1'b0;
      frame_cnt <= '0;
    end else begin
      frame_start <= 1'b0;
      case (state)
        FILL:
          if (accept) begin
            if (bit_cnt == PAY_LAST) begin
              state <= SEND_SYNC;
              bit_cnt <= '0;
              data_out <= SYNC_WORD[SYNC_W-1];
              data_out_valid <= 1'b1;
              frame_start <= 1'b1;
            end else bit_cnt <= bit_cnt + 1'b1;
          end
        SEND_SYNC:
          if (bit_cnt == SYNC_LAST) begin
            state <= SEND_PAYLOAD;
            bit_cnt <= '0;
            data_out <= head;
          end else begin
            data_out <= sync_bit;
            bit_cnt <= bit_cnt + 1'b1;
          end
        SEND_PAYLOAD:
          if (bit_cnt == PAY_LAST) begin
            state <= FILL;
            bit_cnt <= '0;
            data_out <= 1'b0;
            data_out_valid <= 1'b0;
            frame_cnt <= frame_cnt + 1'b1;
          end else begin
            data_out <= head;
            bit_cnt <= bit_cnt + 1'b1;
          end
        default: state <= FILL;
      endcase
    end
endmodule
